// File: rtl/alu_result_serializer.sv
// Transmit side of the ALU result interface: takes one full-width result and sends it
// least-significant beat first, with a one-entry holding register for back-to-back results.
module alu_result_serializer #(
    parameter int RESULT_BUS_WIDTH = 8,
    parameter int RESULT_WIDTH     = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [RESULT_WIDTH-1:0]     in_result,
    input  logic                        flush,
    output logic                        result_valid,
    output logic [RESULT_BUS_WIDTH-1:0] result,
    output logic                        result_last,
    output logic                        result_rst,
    output logic [1:0]                  dbg_state
);
    localparam int BEATS = RESULT_WIDTH / RESULT_BUS_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        ANNOUNCE = 2'd0,
        IDLE     = 2'd1,
        SEND     = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [RESULT_WIDTH-1:0] shreg_q, shreg_d;
    logic [RESULT_WIDTH-1:0] hold_q, hold_d;
    logic                    hold_full_q, hold_full_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    accept;

    // Input handshake: a result transfers on any cycle where in_valid && in_ready are both
    // high at the clock edge; in_ready never depends on in_valid, and flush forces it low.
    assign in_ready = !flush && ((state_q == IDLE) || (state_q == SEND && !hold_full_q));
    assign accept   = in_valid && in_ready;
    assign dbg_state = state_q;

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        result_valid = 1'b0;
        result       = '0;
        result_last  = 1'b0;
        result_rst   = 1'b0;

        case (state_q)
            ANNOUNCE: begin
                // Held quiet while reset is asserted; pulses once on the first free cycle.
                result_rst = !rst;
                state_d    = IDLE;
            end
            IDLE: begin
                if (accept) begin
                    shreg_d = in_result;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                result_valid = 1'b1;
                result       = shreg_q[RESULT_BUS_WIDTH-1:0];
                result_last  = (cnt_q == LAST_CNT);
                if (cnt_q == LAST_CNT) begin
                    if (hold_full_q) begin
                        shreg_d     = hold_q;
                        cnt_d       = '0;
                        hold_full_d = 1'b0;
                    end else if (accept) begin
                        shreg_d = in_result;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    shreg_d = shreg_q >> RESULT_BUS_WIDTH;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (accept) begin
                        hold_d      = in_result;
                        hold_full_d = 1'b1;
                    end
                end
            end
            FLUSH: begin
                result_rst  = 1'b1;
                hold_full_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = ANNOUNCE;
        endcase

        if (flush && state_q != ANNOUNCE) begin
            state_d     = FLUSH;
            hold_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ANNOUNCE;
            shreg_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed bench for alu_result_serializer: announce pulse, single and back-to-back results,
// flush with a held result, reset mid-result, and flush colliding with in_valid.
module tb_alu_result_serializer;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        flush;
    logic        result_valid;
    logic [7:0]  result;
    logic        result_last;
    logic        result_rst;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    alu_result_serializer #(
        .RESULT_BUS_WIDTH(8),
        .RESULT_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_result(in_result),
        .flush(flush),
        .result_valid(result_valid),
        .result(result),
        .result_last(result_last),
        .result_rst(result_rst),
        .dbg_state(dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, apply inputs 1ns after the edge, settle, then let the caller check.
    task automatic drive(input logic v, input logic [31:0] d, input logic f, input logic r);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_result = d;
        flush     = f;
        rst       = r;
        #1;
    endtask

    task automatic exp_beat(input string tag, input logic [7:0] b, input logic l);
        check({tag, ".valid"}, 32'(result_valid), 32'd1);
        check({tag, ".data"},  32'(result),       32'(b));
        check({tag, ".last"},  32'(result_last),  32'(l));
        check({tag, ".rst"},   32'(result_rst),   32'd0);
    endtask

    task automatic exp_quiet(input string tag, input logic r, input logic rdy);
        check({tag, ".valid"}, 32'(result_valid), 32'd0);
        check({tag, ".data"},  32'(result),       32'd0);
        check({tag, ".last"},  32'(result_last),  32'd0);
        check({tag, ".rst"},   32'(result_rst),   32'(r));
        check({tag, ".ready"}, 32'(in_ready),     32'(rdy));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_result = '0; flush = 1'b0;

        // reset and announce
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        exp_quiet("in_reset", 0, 0);
        drive(0, 0, 0, 0);
        exp_quiet("announce", 1, 0);
        drive(0, 0, 0, 0);
        exp_quiet("idle0", 0, 1);

        // single result 0xDEADBEEF
        drive(1, 32'hDEADBEEF, 0, 0);
        check("single.ready", 32'(in_ready), 32'd1);
        drive(0, 0, 0, 0); exp_beat("single.b0", 8'hEF, 0);
        drive(0, 0, 0, 0); exp_beat("single.b1", 8'hBE, 0);
        drive(0, 0, 0, 0); exp_beat("single.b2", 8'hAD, 0);
        drive(0, 0, 0, 0); exp_beat("single.b3", 8'hDE, 1);
        drive(0, 0, 0, 0); exp_quiet("single.after", 0, 1);

        // back-to-back via holding register
        drive(1, 32'h11223344, 0, 0);
        check("b2b.ready0", 32'(in_ready), 32'd1);
        drive(1, 32'h55667788, 0, 0); exp_beat("b2b.b0", 8'h44, 0);
        check("b2b.ready1", 32'(in_ready), 32'd1);
        drive(0, 0, 0, 0); exp_beat("b2b.b1", 8'h33, 0);
        check("b2b.ready_full", 32'(in_ready), 32'd0);
        drive(0, 0, 0, 0); exp_beat("b2b.b2", 8'h22, 0);
        drive(0, 0, 0, 0); exp_beat("b2b.b3", 8'h11, 1);
        drive(0, 0, 0, 0); exp_beat("b2b.b4", 8'h88, 0);
        drive(0, 0, 0, 0); exp_beat("b2b.b5", 8'h77, 0);
        drive(0, 0, 0, 0); exp_beat("b2b.b6", 8'h66, 0);
        drive(0, 0, 0, 0); exp_beat("b2b.b7", 8'h55, 1);
        drive(0, 0, 0, 0); exp_quiet("b2b.after", 0, 1);

        // flush during second beat with a result held
        drive(1, 32'hCAFEF00D, 0, 0);
        drive(1, 32'h12345678, 0, 0); exp_beat("fl.b0", 8'h0D, 0);
        drive(0, 0, 1, 0); exp_beat("fl.b1", 8'hF0, 0);
        check("fl.ready_flush", 32'(in_ready), 32'd0);
        drive(0, 0, 0, 0); exp_quiet("fl.pulse", 1, 0);
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0); exp_quiet("fl.idle", 0, 1);
        end

        // reset mid-result
        drive(1, 32'hA1B2C3D4, 0, 0);
        drive(0, 0, 0, 0); exp_beat("mr.b0", 8'hD4, 0);
        drive(0, 0, 0, 1); exp_beat("mr.b1", 8'hC3, 0);
        drive(0, 0, 0, 1); exp_quiet("mr.in_reset", 0, 0);
        drive(0, 0, 0, 0); exp_quiet("mr.announce", 1, 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0); exp_quiet("mr.idle", 0, 1);
        end

        // flush collides with in_valid in IDLE
        drive(1, 32'hFFFFFFFF, 1, 0);
        check("col.ready", 32'(in_ready), 32'd0);
        drive(0, 0, 0, 0); exp_quiet("col.pulse", 1, 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0); exp_quiet("col.idle", 0, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
